iter_shift_reg: RTL and testbench
=================================

ITER_SHIFT_REG -- requirements
Module: iter_shift_reg

Interface
REQ-001 Parameter WIDTH, default 8: shift register data width, at least 2.
REQ-002 Parameter CNT_W, default 4: width of the shift-amount input, at least 1.
REQ-003 clk  input  1: single clock; all state updates on the rising edge.
REQ-004 rst  input  1: asynchronous, active-low reset.
REQ-005 in  input  WIDTH: parallel load data.
REQ-006 load  input  1: parallel load request.
REQ-007 start  input  1: begin an iterative shift operation.
REQ-008 dir  input  1: 0 = shift right (toward LSB), 1 = shift left (toward MSB).
REQ-009 mode  input  2: 00 logical, 01 arithmetic, 10 rotate, 11 serial-fill.
REQ-010 amt  input  CNT_W: number of single-bit shift steps, 0 to 2^CNT_W-1.
REQ-011 ex  input  1: serial fill bit used in mode 11.
REQ-012 out  output  WIDTH: registered register contents.
REQ-013 busy  output  1: high while a shift operation is in progress.
REQ-014 done  output  1: one-cycle completion pulse.
REQ-015 ser_out  output  1: registered copy of the bit most recently shifted out.

Function
REQ-016 The FSM SHALL have three states: IDLE, SHIFT and DONE; state, step counter and all outputs are registers.
REQ-017 In IDLE, load=1 SHALL set out<=in on the next edge; load has priority over start in the same cycle, and that start is dropped.
REQ-018 In IDLE, start=1 with load=0 and amt!=0 SHALL latch amt, dir and mode, set busy=1, and enter SHIFT.
REQ-019 In IDLE, start=1 with load=0 and amt==0 SHALL enter DONE without asserting busy; out and ser_out are unchanged.
REQ-020 In SHIFT, each cycle SHALL perform exactly one single-bit shift using the latched dir and mode, and SHALL decrement the counter.
REQ-021 Once amt shifts have completed, the block SHALL move to DONE, with busy held high for exactly amt cycles.
REQ-022 DONE SHALL last one cycle with done=1 and busy=0, then return to IDLE.
REQ-023 load and start SHALL be ignored in SHIFT and DONE; amt, dir and mode changes SHALL have no effect after they are latched.
REQ-024 Fill bit, logical mode: 0.
REQ-025 Fill bit, arithmetic mode: the current MSB for right shifts; 0 for left shifts.
REQ-026 Fill bit, rotate mode: the bit shifted out.
REQ-027 Fill bit, serial-fill mode: ex, sampled every shift cycle, not latched.
REQ-028 ser_out SHALL update on every shift cycle: out[0] for right shifts, out[WIDTH-1] for left shifts, taken before the shift.
REQ-029 An amt of WIDTH or more SHALL be performed literally, one step per cycle, with no modulo reduction (rotate wraps naturally; logical left or right clears the register).

Reset
REQ-030 While rst=0, regardless of clk, the block SHALL force: out=0, busy=0, done=0, ser_out=0, counter=0, state=IDLE.
REQ-031 Reset asserted mid-operation SHALL abort the operation with no done pulse, and reset SHALL release into IDLE.

Verification (WIDTH=8, CNT_W=4)
REQ-032 Reset: rst low during SHIFT -> out=8'h00, busy=0 immediately (no clock edge); no done pulse after release.
REQ-033 Logical right: load 8'hB4; start, dir=0, mode=00, amt=3 -> busy high 3 cycles, then out=8'h16, ser_out=1, done pulse for 1 cycle.
REQ-034 Arithmetic right: load 8'h90; start, dir=0, mode=01, amt=2 -> out=8'hE4.
REQ-035 Rotate left: load 8'h81; start, dir=1, mode=10, amt=1 -> out=8'h03, ser_out=1; then start with amt=9 -> out=8'h06 after 9 busy cycles.
REQ-036 Serial fill: load 8'h00; start, dir=0, mode=11, ex=1, amt=4 -> out=8'hF0; start held during SHIFT has no effect, and exactly one done pulse occurs.
REQ-037 Edge cases: start with amt=0 -> done one cycle later, busy never high, out unchanged; load and start together in IDLE -> out=in, busy stays 0.

Source files
------------

// File: rtl/iter_shift_reg_if.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iter_shift_reg_if                                                 |
// | Control/data bundle for the iterative shift register.             |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
interface iter_shift_reg_if #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
);
  logic [WIDTH-1:0] in;
  logic             load;
  logic             start;
  logic             dir;
  logic [1:0]       mode;
  logic [CNT_W-1:0] amt;
  logic             ex;
  logic [WIDTH-1:0] out;
  logic             busy;
  logic             done;
  logic             ser_out;

  modport master (
    output in, load, start, dir, mode, amt, ex,
    input  out, busy, done, ser_out
  );

  modport slave (
    input  in, load, start, dir, mode, amt, ex,
    output out, busy, done, ser_out
  );
endinterface
`default_nettype wire

// File: rtl/iter_shift_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | iter_shift_reg                                                    |
// | Loadable register shifted one bit per cycle, amt times per start. |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module iter_shift_reg #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 4
) (
  input  logic            clk,
  input  logic            rst,
  iter_shift_reg_if.slave bus
);

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_SHIFT = 2'd1;
  localparam logic [1:0] c_DONE  = 2'd2;

  localparam logic [1:0] c_MODE_LOG = 2'b00;
  localparam logic [1:0] c_MODE_ARI = 2'b01;
  localparam logic [1:0] c_MODE_ROT = 2'b10;
  localparam logic [1:0] c_MODE_SER = 2'b11;

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("iter_shift_reg: WIDTH must be at least 2");
    end
    if (CNT_W < 1) begin : g_cnt_check
      $error("iter_shift_reg: CNT_W must be at least 1");
    end
  endgenerate

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_dir;
  logic [1:0]       r_mode;
  logic [WIDTH-1:0] r_out;
  logic             r_busy;
  logic             r_done;
  logic             r_ser;

  logic             w_fill;
  logic             w_shout;
  logic [WIDTH-1:0] w_next;

  // Serial-fill mode takes ex live each step; everything else uses latched controls.
  always_comb begin
    w_fill = 1'b0;
    case (r_mode)
      c_MODE_LOG: w_fill = 1'b0;
      c_MODE_ARI: w_fill = r_dir ? 1'b0 : r_out[WIDTH-1];
      c_MODE_ROT: w_fill = r_dir ? r_out[WIDTH-1] : r_out[0];
      c_MODE_SER: w_fill = bus.ex;
      default:    w_fill = 1'b0;
    endcase
    w_shout = r_dir ? r_out[WIDTH-1] : r_out[0];
    w_next  = r_dir ? {r_out[WIDTH-2:0], w_fill} : {w_fill, r_out[WIDTH-1:1]};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= c_IDLE;
      r_cnt   <= '0;
      r_dir   <= 1'b0;
      r_mode  <= c_MODE_LOG;
      r_out   <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_ser   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          r_done <= 1'b0;
          if (bus.load) begin
            r_out <= bus.in;
          end else if (bus.start) begin
            r_dir  <= bus.dir;
            r_mode <= bus.mode;
            if (bus.amt != '0) begin
              r_cnt   <= bus.amt;
              r_busy  <= 1'b1;
              r_state <= c_SHIFT;
            end else begin
              r_done  <= 1'b1;
              r_state <= c_DONE;
            end
          end
        end
        c_SHIFT: begin
          r_out <= w_next;
          r_ser <= w_shout;
          r_cnt <= r_cnt - CNT_W'(1);
          // Last step: busy drops on the same edge done rises.
          if (r_cnt == CNT_W'(1)) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= c_DONE;
          end
        end
        c_DONE: begin
          r_done  <= 1'b0;
          r_state <= c_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= c_IDLE;
        end
      endcase
    end
  end

  assign bus.out     = r_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;
  assign bus.ser_out = r_ser;

endmodule
`default_nettype wire

// File: tb/tb_iter_shift_reg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | tb_iter_shift_reg                                                 |
// | Directed self-checking bench for iter_shift_reg (WIDTH=8).        |
// | Rev 1.0                                                           |
// +------------------------------------------------------------------+
module tb_iter_shift_reg;

  logic clk;
  logic rst;
  int   checks;
  int   errors;

  iter_shift_reg_if #(.WIDTH(8), .CNT_W(4)) bus ();

  iter_shift_reg #(.WIDTH(8), .CNT_W(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_load(input logic [7:0] v);
    @(negedge clk);
    bus.in   = v;
    bus.load = 1'b1;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  // Pulses start (or holds it until done) and watches a fixed window;
  // controls are scrambled after the start edge to prove they were latched.
  task automatic run_shift(input logic d, input logic [1:0] m, input logic [3:0] a,
                           input logic e, input bit hold,
                           output int busy_n, output int done_n, output int first_done,
                           output logic [7:0] out_d, output logic ser_d);
    busy_n = 0; done_n = 0; first_done = -1; out_d = 8'hxx; ser_d = 1'bx;
    bus.start = 1'b1; bus.dir = d; bus.mode = m; bus.amt = a; bus.ex = e;
    for (int n = 0; n < int'(a) + 4; n++) begin
      @(negedge clk);
      if (n == 0) begin
        if (!hold) bus.start = 1'b0;
        bus.dir = ~d; bus.mode = ~m; bus.amt = ~a;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        done_n++;
        if (first_done < 0) begin
          first_done = n; out_d = bus.out; ser_d = bus.ser_out;
        end
        bus.start = 1'b0;
      end
    end
    bus.start = 1'b0;
  endtask

  task automatic test_reset;
    checks++;
    if ({bus.out, bus.busy, bus.done, bus.ser_out} !== 11'h000) begin
      errors++;
      $display("FAIL reset_state: got out=%h busy=%b done=%b ser=%b, want all 0",
               bus.out, bus.busy, bus.done, bus.ser_out);
    end
  endtask

  task automatic test_logical_right;
    int bn, dn, fd; logic [7:0] o; logic s;
    do_load(8'hB4);
    checks++;
    if (bus.out !== 8'hB4) begin errors++; $display("FAIL load_b4: got %h want b4", bus.out); end
    run_shift(1'b0, 2'b00, 4'd3, 1'b0, 1'b0, bn, dn, fd, o, s);
    checks++;
    if (bn !== 3) begin errors++; $display("FAIL lsr_busy_cycles: got %0d want 3", bn); end
    checks++;
    if (dn !== 1 || fd !== 3) begin errors++; $display("FAIL lsr_done: got %0d pulses first at %0d, want 1 at 3", dn, fd); end
    checks++;
    if (o !== 8'h16 || s !== 1'b1) begin errors++; $display("FAIL lsr_result: got out=%h ser=%b want 16/1", o, s); end
  endtask

  task automatic test_arith_right;
    int bn, dn, fd; logic [7:0] o; logic s;
    do_load(8'h90);
    run_shift(1'b0, 2'b01, 4'd2, 1'b0, 1'b0, bn, dn, fd, o, s);
    checks++;
    if (o !== 8'hE4 || s !== 1'b0 || bn !== 2) begin
      errors++; $display("FAIL asr: got out=%h ser=%b busy=%0d want e4/0/2", o, s, bn);
    end
  endtask

  task automatic test_rotate_left;
    int bn, dn, fd; logic [7:0] o; logic s;
    do_load(8'h81);
    run_shift(1'b1, 2'b10, 4'd1, 1'b0, 1'b0, bn, dn, fd, o, s);
    checks++;
    if (o !== 8'h03 || s !== 1'b1 || bn !== 1) begin
      errors++; $display("FAIL rol1: got out=%h ser=%b busy=%0d want 03/1/1", o, s, bn);
    end
    run_shift(1'b1, 2'b10, 4'd9, 1'b0, 1'b0, bn, dn, fd, o, s);
    checks++;
    if (o !== 8'h06 || s !== 1'b0 || bn !== 9 || dn !== 1) begin
      errors++; $display("FAIL rol9: got out=%h ser=%b busy=%0d done=%0d want 06/0/9/1", o, s, bn, dn);
    end
  endtask

  task automatic test_serial_fill;
    int bn, dn, fd; logic [7:0] o; logic s;
    do_load(8'h00);
    run_shift(1'b0, 2'b11, 4'd4, 1'b1, 1'b1, bn, dn, fd, o, s);
    checks++;
    if (o !== 8'hF0 || bn !== 4) begin errors++; $display("FAIL serfill: got out=%h busy=%0d want f0/4", o, bn); end
    checks++;
    if (dn !== 1) begin errors++; $display("FAIL serfill_done_count: got %0d want 1", dn); end
  endtask

  task automatic test_logical_left_clear;
    int bn, dn, fd; logic [7:0] o; logic s;
    do_load(8'hFF);
    run_shift(1'b1, 2'b00, 4'd9, 1'b0, 1'b0, bn, dn, fd, o, s);
    checks++;
    if (o !== 8'h00 || s !== 1'b0 || bn !== 9) begin
      errors++; $display("FAIL lsl9_clear: got out=%h ser=%b busy=%0d want 00/0/9", o, s, bn);
    end
    do_load(8'h81);
    run_shift(1'b1, 2'b01, 4'd1, 1'b0, 1'b0, bn, dn, fd, o, s);
    checks++;
    if (o !== 8'h02 || s !== 1'b1) begin errors++; $display("FAIL asl1: got out=%h ser=%b want 02/1", o, s); end
  endtask

  task automatic test_amt_zero;
    int bn, dn, fd; logic [7:0] o; logic s;
    do_load(8'h5A);
    run_shift(1'b0, 2'b00, 4'd0, 1'b0, 1'b0, bn, dn, fd, o, s);
    checks++;
    if (bn !== 0 || dn !== 1 || fd !== 0) begin
      errors++; $display("FAIL amt0_timing: got busy=%0d done=%0d first=%0d want 0/1/0", bn, dn, fd);
    end
    checks++;
    if (o !== 8'h5A || bus.out !== 8'h5A) begin errors++; $display("FAIL amt0_out: got %h want 5a", bus.out); end
  endtask

  task automatic test_load_start;
    int busy_seen;
    busy_seen = 0;
    @(negedge clk);
    bus.in = 8'h3C; bus.load = 1'b1; bus.start = 1'b1; bus.amt = 4'd5;
    @(negedge clk);
    bus.load = 1'b0; bus.start = 1'b0;
    for (int n = 0; n < 8; n++) begin
      if (bus.busy || bus.done) busy_seen++;
      @(negedge clk);
    end
    checks++;
    if (bus.out !== 8'h3C || busy_seen !== 0) begin
      errors++; $display("FAIL load_start: got out=%h busy/done cycles=%0d want 3c/0", bus.out, busy_seen);
    end
  endtask

  task automatic test_reset_mid_shift;
    int seen;
    seen = 0;
    do_load(8'hB4);
    bus.start = 1'b1; bus.dir = 1'b0; bus.mode = 2'b00; bus.amt = 4'd10;
    @(negedge clk); bus.start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (bus.busy !== 1'b1 || bus.out !== 8'h2D) begin
      errors++; $display("FAIL pre_reset: got busy=%b out=%h want 1/2d", bus.busy, bus.out);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({bus.out, bus.busy, bus.done, bus.ser_out} !== 11'h000) begin
      errors++; $display("FAIL async_reset: got out=%h busy=%b done=%b ser=%b want all 0",
                         bus.out, bus.busy, bus.done, bus.ser_out);
    end
    @(negedge clk); rst = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (bus.busy || bus.done) seen++;
    end
    checks++;
    if (seen !== 0) begin errors++; $display("FAIL reset_abort: got %0d busy/done cycles want 0", seen); end
    do_load(8'hAA);
    checks++;
    if (bus.out !== 8'hAA) begin errors++; $display("FAIL post_reset_idle: got %h want aa", bus.out); end
  endtask

  initial begin
    checks = 0; errors = 0;
    rst = 1'b0;
    bus.in = '0; bus.load = 1'b0; bus.start = 1'b0; bus.dir = 1'b0;
    bus.mode = 2'b00; bus.amt = '0; bus.ex = 1'b0;
    #3;
    test_reset;
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    test_reset;
    test_logical_right;
    test_arith_right;
    test_rotate_left;
    test_serial_fill;
    test_logical_left_clear;
    test_amt_zero;
    test_load_start;
    test_reset_mid_shift;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
